// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared MIPS fetch definitions: widths, NOP, reset PC, fetch states
package fetch_unit_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_out_buf.sv
// rtl/fetch_out_buf.sv - one-entry valid/ready buffer holding {pc, instr} toward IF/ID
module fetch_out_buf
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fill,
    input  logic               flush,
    input  logic               ready,
    input  logic [ADDR_W-1:0]  in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               valid,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr
);

    // Flush beats fill, fill beats drain; payload only moves on an accepted fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP_INSTR;
        end else begin
            if (flush) begin
                valid <= 1'b0;
            end else if (fill) begin
                valid <= 1'b1;
            end else if (ready) begin
                valid <= 1'b0;
            end
            if (fill && !flush) begin
                pc    <= in_pc;
                instr <= in_instr;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MIPS instruction fetch: PC, single-outstanding imem requests, redirect flush
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic [ADDR_W-1:0] redirect_target;
    logic              discard;
    logic              granted;
    logic              fill;

    assign redirect_target = redirect_pc & ~ADDR_W'(3);
    assign granted         = (state == REQ) && imem_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Only issue once the output buffer is guaranteed to have room for the reply.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!out_valid || out_ready) state_next = REQ;
            REQ:     if (imem_gnt)                state_next = WAIT;
            WAIT:    if (imem_rvalid)             state_next = IDLE;
            default:                              state_next = IDLE;
        endcase
    end

    always_comb begin
        imem_req  = (state == REQ);
        imem_addr = (state == REQ) ? pc : '0;
        fill      = (state == WAIT) && imem_rvalid && !discard && !redirect_valid;
    end

    // A redirect while a request is in flight marks its response as stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            req_pc  <= '0;
            discard <= 1'b0;
        end else begin
            if (redirect_valid) begin
                pc <= redirect_target;
            end else if (granted) begin
                pc <= pc + ADDR_W'(4);
            end
            if (granted) begin
                req_pc <= pc;
            end
            if ((state == WAIT) && imem_rvalid) begin
                discard <= 1'b0;
            end else if (redirect_valid && (granted || (state == WAIT))) begin
                discard <= 1'b1;
            end
        end
    end

    fetch_out_buf #(
        .ADDR_W (ADDR_W)
    ) u_out_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .fill     (fill),
        .flush    (redirect_valid),
        .ready    (out_ready),
        .in_pc    (req_pc),
        .in_instr (imem_rdata),
        .valid    (out_valid),
        .pc       (out_pc),
        .instr    (out_instr)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          gnt_wait;
        logic [31:0] rdata;
        int          stall;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[4];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every accepted transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_pc", out_pc, e.pc);
                check("sb_instr", out_instr, e.instr);
            end
        end
    end

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 50) begin
            step();
            n++;
        end
        check("req_timeout", 32'(imem_req), 32'd1);
    endtask

    task automatic req_grant(input logic [31:0] addr, input int gnt_wait);
        wait_req();
        check("req_addr", imem_addr, addr);
        for (int i = 0; i < gnt_wait; i++) begin
            step();
            check("req_held", 32'(imem_req), 32'd1);
            check("addr_stable", imem_addr, addr);
        end
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        check("wait_no_req", 32'(imem_req), 32'd0);
    endtask

    task automatic do_fetch(input logic [31:0] addr, input int gnt_wait, input logic [31:0] rdata);
        exp_t e;
        req_grant(addr, gnt_wait);
        e.pc = addr;
        e.instr = rdata;
        sb.push_back(e);
        imem_rvalid = 1'b1;
        imem_rdata = rdata;
        step();
        imem_rvalid = 1'b0;
        check("fill_valid", 32'(out_valid), 32'd1);
        check("fill_pc", out_pc, addr);
        check("fill_instr", out_instr, rdata);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        vecs[0] = '{addr: 32'h0000_0000, gnt_wait: 0, rdata: 32'h2008_0005, stall: 0};
        vecs[1] = '{addr: 32'h0000_0004, gnt_wait: 0, rdata: 32'h8C09_0004, stall: 5};
        vecs[2] = '{addr: 32'h0000_0008, gnt_wait: 3, rdata: 32'h0109_5020, stall: 0};
        vecs[3] = '{addr: 32'h0000_000C, gnt_wait: 1, rdata: 32'hAC0A_0008, stall: 2};

        step();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_instr", out_instr, 32'h0);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            do_fetch(vecs[k].addr, vecs[k].gnt_wait, vecs[k].rdata);
            if (vecs[k].stall > 0) begin
                out_ready = 1'b0;
                for (int s = 0; s < vecs[k].stall; s++) begin
                    step();
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_pc", out_pc, vecs[k].addr);
                    check("stall_instr", out_instr, vecs[k].rdata);
                    check("stall_no_req", 32'(imem_req), 32'd0);
                end
                out_ready = 1'b1;
            end
        end

        // Redirect while waiting; its response must be dropped.
        req_grant(32'h0000_0010, 0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        check("wait_redir_drop", 32'(out_valid), 32'd0);
        do_fetch(32'h0000_0100, 0, 32'h2402_0001);

        // Redirect coinciding with rvalid.
        req_grant(32'h0000_0104, 0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        redirect_valid = 1'b0;
        imem_rvalid = 1'b0;
        check("rvalid_redir_drop", 32'(out_valid), 32'd0);
        do_fetch(32'h0000_0200, 0, 32'h2403_0002);

        // Redirect coinciding with gnt.
        wait_req();
        check("gnt_redir_addr", imem_addr, 32'h0000_0204);
        imem_gnt = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0300;
        step();
        imem_gnt = 1'b0;
        redirect_valid = 1'b0;
        check("gnt_redir_wait", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata = 32'hCAFE_BABE;
        step();
        imem_rvalid = 1'b0;
        check("gnt_redir_drop", 32'(out_valid), 32'd0);
        do_fetch(32'h0000_0300, 0, 32'h2404_0003);

        // Back-to-back redirects while waiting: last one wins.
        req_grant(32'h0000_0304, 0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0400;
        step();
        redirect_pc = 32'h0000_0500;
        step();
        redirect_valid = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h1111_2222;
        step();
        imem_rvalid = 1'b0;
        check("b2b_drop", 32'(out_valid), 32'd0);
        wait_req();
        check("b2b_addr", imem_addr, 32'h0000_0500);

        // Redirect in REQ without gnt, low bits forced to zero, then wrap.
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        check("req_redir_req", 32'(imem_req), 32'd1);
        check("req_redir_addr", imem_addr, 32'hFFFF_FFFC);
        do_fetch(32'hFFFF_FFFC, 0, 32'h2405_0004);
        do_fetch(32'h0000_0000, 0, 32'h2406_0005);

        // Asynchronous reset in WAIT, then a stale response.
        req_grant(32'h0000_0004, 0);
        rst_n = 1'b0;
        #1;
        check("arst_req", 32'(imem_req), 32'd0);
        check("arst_addr", imem_addr, 32'h0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_pc", out_pc, 32'h0);
        check("arst_instr", out_instr, 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        step();
        rst_n = 1'b1;
        step();
        imem_rvalid = 1'b0;
        check("stale_ignored", 32'(out_valid), 32'd0);
        do_fetch(32'h0000_0000, 0, 32'h2407_0006);

        step();
        step();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
